// File: rtl/sram_arbiter.sv
// Two-port (fetch / data) arbiter that serializes requests into single accesses on the sram_controller bus.
// Optional round-robin tie-breaking is enabled by defining SRAM_ARB_ROUND_ROBIN_EN; default is data-port priority.
module sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_be,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic              read_op,
    output logic              write_op,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_data_write,
    output logic [3:0]        byte_mask,
    input  logic [31:0]       bus_data_read
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] count;
    logic       grant_data;
    logic       dir_we;
    logic       take;
    logic       pick_data;
    logic       tie_fetch;
    logic       op_we_next;
    logic       read_op_d;
    logic       write_op_d;
    logic       if_ready_d;
    logic       mem_ready_d;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Set when the fetch port should win the next tie (it was not granted last).
    logic rr_fetch_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_fetch_next <= 1'b1;
        end else if (take) begin
            rr_fetch_next <= pick_data;
        end
    end

    assign tie_fetch = rr_fetch_next;
`else
    assign tie_fetch = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take       = 1'b0;
        pick_data  = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || mem_req) begin
                    take       = 1'b1;
                    pick_data  = mem_req && (!if_req || !tie_fetch);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so every port below comes straight from a flop.
    always_comb begin
        op_we_next  = take ? (pick_data && mem_we) : dir_we;
        read_op_d   = (state_next == BUSY) && !op_we_next;
        write_op_d  = (state_next == BUSY) && op_we_next;
        if_ready_d  = (state_next == DONE) && !grant_data;
        mem_ready_d = (state_next == DONE) && grant_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_op        <= 1'b0;
            write_op       <= 1'b0;
            if_ready       <= 1'b0;
            mem_ready      <= 1'b0;
            bus_addr       <= '0;
            bus_data_write <= '0;
            byte_mask      <= '0;
            if_rdata       <= '0;
            mem_rdata      <= '0;
            grant_data     <= 1'b0;
            dir_we         <= 1'b0;
            count          <= '0;
        end else begin
            read_op   <= read_op_d;
            write_op  <= write_op_d;
            if_ready  <= if_ready_d;
            mem_ready <= mem_ready_d;
            if (take) begin
                grant_data     <= pick_data;
                dir_we         <= pick_data && mem_we;
                bus_addr       <= pick_data ? mem_addr : if_addr;
                bus_data_write <= pick_data ? mem_wdata : 32'd0;
                byte_mask      <= pick_data ? mem_be : 4'b1111;
                count          <= 4'(ACCESS_CYCLES - 1);
            end else if (state == BUSY && count != 4'd0) begin
                count <= count - 4'd1;
            end
            // Read data is sampled on the last cycle of the access window.
            if (state == BUSY && count == 4'd0 && !dir_we) begin
                if (grant_data) begin
                    mem_rdata <= bus_data_read;
                end else begin
                    if_rdata <= bus_data_read;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM stand-in, reference memory, scoreboard of expected ready events.
// A second instance with ACCESS_CYCLES=1 covers the back-to-back case.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [19:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        read_op;
    logic        write_op;
    logic [19:0] bus_addr;
    logic [31:0] bus_data_write;
    logic [3:0]  byte_mask;
    logic [31:0] bus_data_read;

    logic        if_req_b;
    logic [19:0] if_addr_b;
    logic [31:0] if_rdata_b;
    logic        if_ready_b;
    logic        mem_req_b;
    logic        mem_we_b;
    logic [19:0] mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [3:0]  mem_be_b;
    logic [31:0] mem_rdata_b;
    logic        mem_ready_b;
    logic        read_op_b;
    logic        write_op_b;
    logic [19:0] bus_addr_b;
    logic [31:0] bus_data_write_b;
    logic [3:0]  byte_mask_b;
    logic [31:0] bus_data_read_b;

    int compared = 0;
    int mismatched = 0;

    logic [32:0] exp_q[$];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] sram [0:4095];
    logic        loaded = 1'b0;
    logic [31:0] exp_mem_rdata;

    sram_arbiter #(.ACCESS_CYCLES(2), .ADDR_W(20)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .read_op(read_op), .write_op(write_op), .bus_addr(bus_addr),
        .bus_data_write(bus_data_write), .byte_mask(byte_mask), .bus_data_read(bus_data_read)
    );

    sram_arbiter #(.ACCESS_CYCLES(1), .ADDR_W(20)) u_dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_ready(if_ready_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_be(mem_be_b), .mem_rdata(mem_rdata_b), .mem_ready(mem_ready_b),
        .read_op(read_op_b), .write_op(write_op_b), .bus_addr(bus_addr_b),
        .bus_data_write(bus_data_write_b), .byte_mask(byte_mask_b), .bus_data_read(bus_data_read_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected run to finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory models ----------------
    function automatic logic [31:0] seed_word(input int a);
        logic [31:0] av;
        av = a;
        if (a == 'h40) return 32'h8C010004;
        return (av * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic logic [31:0] rd_fn(input logic [19:0] a);
        return {12'hA5A, a};
    endfunction

    assign bus_data_read   = sram[bus_addr[11:0]];
    assign bus_data_read_b = rd_fn(bus_addr_b);

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) sram[i] <= seed_word(i);
            loaded <= 1'b1;
        end else if (write_op) begin
            for (int b = 0; b < 4; b++)
                if (byte_mask[b]) sram[bus_addr[11:0]][8*b +: 8] <= bus_data_write[8*b +: 8];
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [32:0] obs;
        logic [32:0] exp;
        if (!rst) begin
            if (read_op || write_op) begin
                compared++;
                if (read_op && write_op) begin
                    mismatched++;
                    $display("FAIL ops_exclusive: read_op=%b write_op=%b, required not both high", read_op, write_op);
                end
            end
            if (if_ready || mem_ready) begin
                compared++;
                obs = {mem_ready, mem_ready ? mem_rdata : if_rdata};
                if (if_ready && mem_ready) begin
                    mismatched++;
                    $display("FAIL ready_exclusive: if_ready=1 mem_ready=1, required only one");
                end else if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_ready: got port=%b data=%h, required no ready", obs[32], obs[31:0]);
                end else begin
                    exp = exp_q.pop_front();
                    if (obs !== exp) begin
                        mismatched++;
                        $display("FAIL ready_data: got port=%b data=%h, required port=%b data=%h",
                                 obs[32], obs[31:0], exp[32], exp[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_be = '0;
        if_req_b = 1'b0; if_addr_b = '0;
        mem_req_b = 1'b0; mem_we_b = 1'b0; mem_addr_b = '0; mem_wdata_b = '0; mem_be_b = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_mem_rdata = '0;
    endtask

    task automatic ref_write(input logic [19:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a[11:0]][8*b +: 8] = d[8*b +: 8];
    endtask

    // Drives one data access and returns the negedge count at which mem_ready appeared (0 = timeout).
    task automatic mem_access(input logic we, input logic [19:0] a, input logic [31:0] d,
                              input logic [3:0] be, output int cycles);
        if (we) ref_write(a, d, be);
        else exp_mem_rdata = ref_mem[a[11:0]];
        exp_q.push_back({1'b1, exp_mem_rdata});
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d; mem_be = be;
        cycles = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (mem_ready) begin cycles = n; break; end
        end
        mem_req = 1'b0;
    endtask

    task automatic if_access(input logic [19:0] a, output int cycles);
        exp_q.push_back({1'b0, ref_mem[a[11:0]]});
        @(negedge clk);
        if_req = 1'b1; if_addr = a;
        cycles = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (if_ready) begin cycles = n; break; end
        end
        if_req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int cyc;
        int seen;
        rst = 1'b1;
        #3;
        compared++;
        if ({read_op, write_op, bus_addr, bus_data_write, byte_mask, if_ready, mem_ready, if_rdata, mem_rdata} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got ops=%b%b addr=%h wd=%h mask=%b rdy=%b%b ird=%h mrd=%h, required all 0",
                     read_op, write_op, bus_addr, bus_data_write, byte_mask, if_ready, mem_ready, if_rdata, mem_rdata);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_mem_rdata = '0;
        // Read of 0x00010 interrupted by a reset pulse inside the access window.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 20'h00010; mem_be = 4'b1111;
        @(negedge clk);
        compared++;
        if (read_op !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_pre_busy: read_op=%b, required 1", read_op);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        compared++;
        if ({read_op, write_op, bus_addr, byte_mask, if_ready, mem_ready, mem_rdata} !== '0) begin
            mismatched++;
            $display("FAIL reset_async: got ops=%b%b addr=%h mask=%b rdy=%b%b mrd=%h, required all 0",
                     read_op, write_op, bus_addr, byte_mask, if_ready, mem_ready, mem_rdata);
        end
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (if_ready || mem_ready) seen++;
        end
        compared++;
        if (seen !== 0) begin
            mismatched++;
            $display("FAIL reset_no_ready: saw %0d ready pulses, required 0", seen);
        end
        mem_access(1'b0, 20'h00010, 32'd0, 4'b1111, cyc);
        compared++;
        if (cyc !== 3) begin
            mismatched++;
            $display("FAIL reset_recover_latency: ready at cycle %0d, required 3", cyc);
        end
    endtask

    task automatic test_fetch_read();
        exp_q.push_back({1'b0, ref_mem[12'h040]});
        @(negedge clk);
        if_req = 1'b1; if_addr = 20'h00040;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            compared++;
            if (n <= 2) begin
                if ({read_op, write_op, byte_mask, bus_addr, if_ready} !== {1'b1, 1'b0, 4'b1111, 20'h00040, 1'b0}) begin
                    mismatched++;
                    $display("FAIL fetch_window[%0d]: ops=%b%b mask=%b addr=%h rdy=%b, required 10 1111 00040 0",
                             n, read_op, write_op, byte_mask, bus_addr, if_ready);
                end
            end else if ({read_op, if_ready, if_rdata} !== {1'b0, 1'b1, 32'h8C010004}) begin
                mismatched++;
                $display("FAIL fetch_done: read_op=%b if_ready=%b if_rdata=%h, required 0 1 8c010004",
                         read_op, if_ready, if_rdata);
            end
        end
        if_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        int cyc;
        ref_write(20'h00123, 32'hDEADBEEF, 4'b0011);
        exp_q.push_back({1'b1, exp_mem_rdata});
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 20'h00123; mem_wdata = 32'hDEADBEEF; mem_be = 4'b0011;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            if (n == 2) begin
                mem_addr = 20'h00FFF; mem_wdata = 32'h0; mem_be = 4'b1111; mem_we = 1'b0;
            end
            compared++;
            if (n <= 2) begin
                if ({write_op, read_op, bus_addr, bus_data_write, byte_mask} !==
                    {1'b1, 1'b0, 20'h00123, 32'hDEADBEEF, 4'b0011}) begin
                    mismatched++;
                    $display("FAIL write_window[%0d]: ops w=%b r=%b addr=%h wd=%h mask=%b, required 1 0 00123 deadbeef 0011",
                             n, write_op, read_op, bus_addr, bus_data_write, byte_mask);
                end
            end else if ({write_op, mem_ready} !== 2'b01) begin
                mismatched++;
                $display("FAIL write_done: write_op=%b mem_ready=%b, required 0 1", write_op, mem_ready);
            end
        end
        mem_req = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (if_rdata !== 32'h8C010004) begin
            mismatched++;
            $display("FAIL write_if_rdata_hold: if_rdata=%h, required 8c010004", if_rdata);
        end
        mem_access(1'b0, 20'h00123, 32'd0, 4'b1111, cyc);
        compared++;
        if (ref_mem[12'h123][15:0] !== 16'hBEEF || cyc !== 3) begin
            mismatched++;
            $display("FAIL write_readback: ready cycle %0d low half %h, required 3 beef", cyc, ref_mem[12'h123][15:0]);
        end
    endtask

    task automatic test_arbitration();
        logic expect_data [4];
        int   t_ready [4];
        int   k;
        apply_reset();
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        expect_data = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        expect_data = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 4; i++) begin
            if (expect_data[i]) begin
                exp_mem_rdata = ref_mem[12'h300];
                exp_q.push_back({1'b1, ref_mem[12'h300]});
            end else begin
                exp_q.push_back({1'b0, ref_mem[12'h200]});
            end
            t_ready[i] = 0;
        end
        @(negedge clk);
        if_req = 1'b1; if_addr = 20'h00200;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 20'h00300; mem_be = 4'b1111;
        k = 0;
        for (int n = 1; n <= 40 && k < 4; n++) begin
            @(negedge clk);
            if (if_ready || mem_ready) begin
                compared++;
                if (mem_ready !== expect_data[k]) begin
                    mismatched++;
                    $display("FAIL arb_grant[%0d]: data_granted=%b, required %b", k, mem_ready, expect_data[k]);
                end
                t_ready[k] = n;
                k++;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (t_ready[i] !== 3 + 4 * i) begin
                mismatched++;
                $display("FAIL arb_spacing[%0d]: ready at cycle %0d, required %0d", i, t_ready[i], 3 + 4 * i);
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_mid_change();
        exp_mem_rdata = ref_mem[12'h0AB];
        exp_q.push_back({1'b1, exp_mem_rdata});
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 20'h000AB; mem_be = 4'b1111;
        @(negedge clk);
        mem_req = 1'b0; mem_addr = 20'h000CD; mem_we = 1'b1;
        @(negedge clk);
        compared++;
        if ({read_op, bus_addr} !== {1'b1, 20'h000AB}) begin
            mismatched++;
            $display("FAIL mid_change_bus: read_op=%b bus_addr=%h, required 1 000ab", read_op, bus_addr);
        end
        @(negedge clk);
        compared++;
        if (mem_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_change_ready: mem_ready=%b, required 1", mem_ready);
        end
        mem_we = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        int cyc;
        int kind;
        logic [19:0] a;
        for (int i = 0; i < 12; i++) begin
            kind = $urandom_range(0, 2);
            a = 20'($urandom_range(0, 4095));
            if (kind == 0) if_access(a, cyc);
            else mem_access(kind == 2, a, $urandom, 4'($urandom_range(0, 15)), cyc);
            compared++;
            if (cyc !== 3) begin
                mismatched++;
                $display("FAIL random_latency[%0d]: ready at cycle %0d, required 3", i, cyc);
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        int overlap;
        t1 = 0; t2 = 0; overlap = 0;
        @(negedge clk);
        mem_req_b = 1'b1; mem_we_b = 1'b0; mem_addr_b = 20'h00001; mem_be_b = 4'b1111;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (read_op_b && write_op_b) overlap++;
            if (mem_ready_b) begin
                compared++;
                if (t1 == 0) begin
                    t1 = n;
                    if (mem_rdata_b !== rd_fn(20'h00001)) begin
                        mismatched++;
                        $display("FAIL b2b_data0: mem_rdata=%h, required %h", mem_rdata_b, rd_fn(20'h00001));
                    end
                    mem_addr_b = 20'h00002;
                end else begin
                    t2 = n;
                    if (mem_rdata_b !== rd_fn(20'h00002)) begin
                        mismatched++;
                        $display("FAIL b2b_data1: mem_rdata=%h, required %h", mem_rdata_b, rd_fn(20'h00002));
                    end
                    break;
                end
            end
        end
        mem_req_b = 1'b0;
        compared++;
        if (t1 !== 2 || t2 - t1 !== 3) begin
            mismatched++;
            $display("FAIL b2b_timing: first ready %0d gap %0d, required 2 and 3", t1, t2 - t1);
        end
        compared++;
        if (overlap !== 0) begin
            mismatched++;
            $display("FAIL b2b_ops_overlap: %0d overlapping cycles, required 0", overlap);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = seed_word(i);
        exp_mem_rdata = '0;
        idle_inputs();
        test_reset();
        test_fetch_read();
        test_write();
        test_mid_change();
        test_random();
        test_back_to_back();
        test_arbitration();
        compared++;
        if (exp_q.size() !== 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d expected ready events never seen, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
